// File: rtl/risc16_exec_core.sv
// risc16_exec_core: execute / memory / write-back stage of the 16-bit
// single-cycle RISC. Holds the register file, ALU with operand-B mux,
// word-addressed data memory and the write-back mux.
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   reg_read_addr_1/2, reg_write_dest register file addresses
//   reg_write                         register write enable
//   imm, alu_src                      immediate and operand-B select
//   alu_control                       ALU operation select
//   mem_write, mem_read, mem_to_reg   data memory / write-back controls
//   reg_read_data_1/2                 register read data (combinational)
//   alu_result, zero                  ALU result and zero flag
//   mem_read_data, wb_data            memory read data, write-back value
//
// Optional feature: define ZERO_REG_EN to hard-wire register 0 to zero.

module risc16_exec_core #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned REG_AW     = 3,
    parameter int unsigned DMEM_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] reg_read_addr_1,
    input  logic [REG_AW-1:0] reg_read_addr_2,
    input  logic [REG_AW-1:0] reg_write_dest,
    input  logic              reg_write,
    input  logic [DATA_W-1:0] imm,
    input  logic              alu_src,
    input  logic [2:0]        alu_control,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic              mem_to_reg,
    output logic [DATA_W-1:0] reg_read_data_1,
    output logic [DATA_W-1:0] reg_read_data_2,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero,
    output logic [DATA_W-1:0] mem_read_data,
    output logic [DATA_W-1:0] wb_data
);

    localparam int unsigned NUM_REGS = 1 << REG_AW;
    localparam int unsigned MEM_AW   = $clog2(DMEM_DEPTH);
    localparam int unsigned SH_W     = $clog2(DATA_W);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] mem  [DMEM_DEPTH];
    logic [DATA_W-1:0] op_b;
    logic [MEM_AW-1:0] mem_idx;
    logic              reg_we;

    // Register read ports: combinational, no write bypass
`ifdef ZERO_REG_EN
    assign reg_read_data_1 = (reg_read_addr_1 == '0) ? '0 : regs[reg_read_addr_1];
    assign reg_read_data_2 = (reg_read_addr_2 == '0) ? '0 : regs[reg_read_addr_2];
    assign reg_we          = reg_write && (reg_write_dest != '0);
`else
    assign reg_read_data_1 = regs[reg_read_addr_1];
    assign reg_read_data_2 = regs[reg_read_addr_2];
    assign reg_we          = reg_write;
`endif

    assign op_b = alu_src ? imm : reg_read_data_2;

    // ALU; shifts use only the low bits of operand B
    always_comb begin
        alu_result = '0;
        case (alu_control)
            3'b000: alu_result = reg_read_data_1 + op_b;
            3'b001: alu_result = reg_read_data_1 - op_b;
            3'b010: alu_result = ~reg_read_data_1;
            3'b011: alu_result = reg_read_data_1 << op_b[SH_W-1:0];
            3'b100: alu_result = reg_read_data_1 >> op_b[SH_W-1:0];
            3'b101: alu_result = reg_read_data_1 & op_b;
            3'b110: alu_result = reg_read_data_1 | op_b;
            3'b111: alu_result = DATA_W'(reg_read_data_1 < op_b);
        endcase
    end

    assign zero = (alu_result == '0);

    // Byte address from the ALU: drop bit 0, upper bits wrap
    assign mem_idx       = alu_result[MEM_AW:1];
    assign mem_read_data = mem_read ? mem[mem_idx] : '0;
    assign wb_data       = mem_to_reg ? mem_read_data : alu_result;

    // Register file write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '{default: '0};
        end else if (reg_we) begin
            regs[reg_write_dest] <= wb_data;
        end
    end

    // Data memory write port; store data always comes from register B
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (mem_write) begin
            mem[mem_idx] <= reg_read_data_2;
        end
    end

endmodule

// File: tb/tb_risc16_exec_core.sv
// Scoreboard bench for risc16_exec_core: stimulus pushes expected outputs
// from an arithmetic reference model; a monitor pops and compares them.

module tb_risc16_exec_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  reg_read_addr_1, reg_read_addr_2, reg_write_dest;
    logic        reg_write;
    logic [15:0] imm;
    logic        alu_src;
    logic [2:0]  alu_control;
    logic        mem_write, mem_read, mem_to_reg;
    logic [15:0] reg_read_data_1, reg_read_data_2, alu_result;
    logic        zero;
    logic [15:0] mem_read_data, wb_data;

    always #5 clk = ~clk;

    risc16_exec_core dut (
        .clk             (clk),
        .rst             (rst),
        .reg_read_addr_1 (reg_read_addr_1),
        .reg_read_addr_2 (reg_read_addr_2),
        .reg_write_dest  (reg_write_dest),
        .reg_write       (reg_write),
        .imm             (imm),
        .alu_src         (alu_src),
        .alu_control     (alu_control),
        .mem_write       (mem_write),
        .mem_read        (mem_read),
        .mem_to_reg      (mem_to_reg),
        .reg_read_data_1 (reg_read_data_1),
        .reg_read_data_2 (reg_read_data_2),
        .alu_result      (alu_result),
        .zero            (zero),
        .mem_read_data   (mem_read_data),
        .wb_data         (wb_data)
    );

    typedef struct packed {
        logic [2:0]  ra1;
        logic [2:0]  ra2;
        logic [2:0]  wd;
        logic        rw;
        logic [15:0] imm;
        logic        asrc;
        logic [2:0]  op;
        logic        mw;
        logic        mr;
        logic        m2r;
    } stim_t;

    typedef struct {
        logic [15:0] rd1, rd2, alu, mrd, wb;
        logic        zero;
        int          csel;
        logic [15:0] cval;
    } exp_t;

    localparam int C_NONE = 0, C_ALU = 1, C_MRD = 2, C_RD1 = 3, C_ZERO = 4;

    int unsigned mregs [8];
    int unsigned mmem  [8];
    exp_t        exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic int unsigned rdreg(input logic [2:0] a);
`ifdef ZERO_REG_EN
        if (a == 3'd0) return 0;
`endif
        return mregs[a];
    endfunction

    function automatic int unsigned alu_ref(input int unsigned a, input int unsigned b,
                                            input logic [2:0] op);
        int unsigned p2;
        p2 = 32'd1 << (b % 16);
        case (op)
            3'd0:    return (a + b) % 65536;
            3'd1:    return (a + 65536 - b) % 65536;
            3'd2:    return 65535 - a;
            3'd3:    return (a * p2) % 65536;
            3'd4:    return a / p2;
            3'd5:    return a & b;
            3'd6:    return a | b;
            default: return (a < b) ? 1 : 0;
        endcase
    endfunction

    function automatic exp_t eval(input stim_t s);
        exp_t        e;
        int unsigned a, b, r, mrd;
        a = rdreg(s.ra1);
        if (s.asrc) b = 32'(s.imm);
        else        b = rdreg(s.ra2);
        r   = alu_ref(a, b, s.op);
        mrd = s.mr ? mmem[(r / 2) % 8] : 0;
        e.rd1  = 16'(a);
        e.rd2  = 16'(rdreg(s.ra2));
        e.alu  = 16'(r);
        e.zero = (r == 0);
        e.mrd  = 16'(mrd);
        e.wb   = s.m2r ? 16'(mrd) : 16'(r);
        e.csel = C_NONE;
        e.cval = 16'h0;
        return e;
    endfunction

    // Apply the writes that the upcoming clock edge performs
    task automatic commit(input stim_t s, input exp_t e);
        if (s.rw) begin
`ifdef ZERO_REG_EN
            if (s.wd != 3'd0)
`endif
            mregs[s.wd] = 32'(e.wb);
        end
        if (s.mw) mmem[(32'(e.alu) / 2) % 8] = 32'(e.rd2);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) begin
            mregs[i] = 0;
            mmem[i]  = 0;
        end
    endtask

    function automatic stim_t mk(input logic [2:0] ra1, input logic [2:0] ra2,
                                 input logic [2:0] wd, input logic rw,
                                 input logic [15:0] im, input logic asrc,
                                 input logic [2:0] op, input logic mw,
                                 input logic mr, input logic m2r);
        stim_t s;
        s.ra1 = ra1; s.ra2 = ra2; s.wd = wd; s.rw = rw; s.imm = im;
        s.asrc = asrc; s.op = op; s.mw = mw; s.mr = mr; s.m2r = m2r;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.ra1  = 3'($urandom);
        s.ra2  = 3'($urandom);
        s.wd   = 3'($urandom);
        s.rw   = 1'($urandom);
        s.imm  = 16'($urandom);
        s.asrc = 1'($urandom);
        s.op   = 3'($urandom);
        s.mw   = 1'($urandom);
        s.mr   = 1'($urandom);
        s.m2r  = 1'($urandom);
        return s;
    endfunction

    task automatic drive(input stim_t s);
        reg_read_addr_1 = s.ra1;
        reg_read_addr_2 = s.ra2;
        reg_write_dest  = s.wd;
        reg_write       = s.rw;
        imm             = s.imm;
        alu_src         = s.asrc;
        alu_control     = s.op;
        mem_write       = s.mw;
        mem_read        = s.mr;
        mem_to_reg      = s.m2r;
    endtask

    task automatic apply(input stim_t s, input int csel, input logic [15:0] cval);
        exp_t e;
        @(posedge clk);
        #1;
        drive(s);
        e      = eval(s);
        e.csel = csel;
        e.cval = cval;
        exp_q.push_back(e);
        commit(s, e);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are settled half a cycle after each stimulus change
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rd1",  reg_read_data_1, e.rd1);
                chk("rd2",  reg_read_data_2, e.rd2);
                chk("alu",  alu_result,      e.alu);
                chk("zero", 16'(zero),       16'(e.zero));
                chk("mrd",  mem_read_data,   e.mrd);
                chk("wb",   wb_data,         e.wb);
                case (e.csel)
                    C_ALU:  chk("const_alu",  alu_result,      e.cval);
                    C_MRD:  chk("const_mrd",  mem_read_data,   e.cval);
                    C_RD1:  chk("const_rd1",  reg_read_data_1, e.cval);
                    C_ZERO: chk("const_zero", 16'(zero),       e.cval);
                    default: ;
                endcase
            end
        end
    end

    initial begin
        stim_t s;
        exp_t  e;

        // Reset held across edges with writes pending: writes must be ignored
        rst = 1'b1;
        clear_model();
        s = mk(3'd1, 3'd2, 3'd1, 1'b1, 16'h0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
        drive(s);
        repeat (2) @(posedge clk);
        #1;
        e = eval(s);
        e.csel = C_ZERO;
        e.cval = 16'h1;
        exp_q.push_back(e);
        @(negedge clk);
        #1 rst = 1'b0;
        commit(s, e);

        // All registers read zero after reset
        for (int i = 0; i < 8; i++)
            apply(mk(3'(i), 3'(i), 3'd0, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0), C_RD1, 16'h0);

        // R1=5, R2=3, subtract
        apply(mk(3'd0, 3'd0, 3'd1, 1'b1, 16'd5, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0), C_ALU, 16'd5);
        apply(mk(3'd0, 3'd0, 3'd2, 1'b1, 16'd3, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0), C_ALU, 16'd3);
        apply(mk(3'd1, 3'd2, 3'd0, 1'b0, 16'h0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0), C_ALU, 16'd2);
        apply(mk(3'd1, 3'd2, 3'd0, 1'b0, 16'h0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0), C_ZERO, 16'd0);
        apply(mk(3'd1, 3'd1, 3'd0, 1'b0, 16'h0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0), C_ZERO, 16'd1);

        // ALU sweep with A=R5=8001, B=R6=0004
        apply(mk(3'd0, 3'd0, 3'd5, 1'b1, 16'h8001, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0), C_ALU, 16'h8001);
        apply(mk(3'd0, 3'd0, 3'd6, 1'b1, 16'h0004, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0), C_ALU, 16'h0004);
        apply(mk(3'd5, 3'd6, 3'd0, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0), C_ALU, 16'h8005);
        apply(mk(3'd5, 3'd6, 3'd0, 1'b0, 16'h0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0), C_ALU, 16'h7FFE);
        apply(mk(3'd5, 3'd6, 3'd0, 1'b0, 16'h0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0), C_ALU, 16'h0010);
        apply(mk(3'd5, 3'd6, 3'd0, 1'b0, 16'h0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0), C_ALU, 16'h0800);
        apply(mk(3'd5, 3'd6, 3'd0, 1'b0, 16'h0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0), C_ALU, 16'h0000);
        apply(mk(3'd5, 3'd6, 3'd0, 1'b0, 16'h0, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0), C_ALU, 16'h8005);
        apply(mk(3'd5, 3'd6, 3'd0, 1'b0, 16'h0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0), C_ALU, 16'h0000);
        apply(mk(3'd0, 3'd0, 3'd7, 1'b1, 16'h0001, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0), C_ALU, 16'h0001);
        apply(mk(3'd7, 3'd0, 3'd0, 1'b0, 16'hFFFF, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0), C_ALU, 16'h0001);

        // Store R2 at address 4, load into R3, check aliases
        apply(mk(3'd0, 3'd2, 3'd0, 1'b0, 16'd4, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0), C_NONE, 16'h0);
        apply(mk(3'd0, 3'd0, 3'd3, 1'b1, 16'd4, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1), C_MRD, 16'd3);
        apply(mk(3'd3, 3'd0, 3'd0, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0), C_RD1, 16'd3);
        apply(mk(3'd0, 3'd0, 3'd0, 1'b0, 16'd5, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1), C_MRD, 16'd3);
        apply(mk(3'd0, 3'd0, 3'd0, 1'b0, 16'd20, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1), C_MRD, 16'd3);
        apply(mk(3'd0, 3'd5, 3'd0, 1'b0, 16'd22, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0), C_MRD, 16'd0);
        apply(mk(3'd0, 3'd0, 3'd0, 1'b0, 16'd6, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0), C_MRD, 16'h8001);

        // Same-cycle write and read of R4: old value, then new value
        apply(mk(3'd4, 3'd0, 3'd4, 1'b1, 16'h0077, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0), C_RD1, 16'h0);
        apply(mk(3'd4, 3'd0, 3'd0, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0), C_RD1, 16'h0077);

        // Randomized traffic
        for (int n = 0; n < 400; n++) apply(rnd(), C_NONE, 16'h0);

        // Asynchronous reset between edges with writes pending
        apply(mk(3'd0, 3'd0, 3'd1, 1'b1, 16'hABCD, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0), C_NONE, 16'h0);
        @(posedge clk);
        #1;
        s = mk(3'd1, 3'd1, 3'd2, 1'b1, 16'h0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
        drive(s);
        #1 rst = 1'b1;
        clear_model();
        e = eval(s);
        e.csel = C_RD1;
        e.cval = 16'h0;
        exp_q.push_back(e);
        @(negedge clk);
        #1 rst = 1'b0;
        commit(s, e);

        for (int i = 0; i < 8; i++)
            apply(mk(3'(i), 3'd0, 3'd0, 1'b0, 16'(2 * i), 1'b1, 3'd0, 1'b0, 1'b1, 1'b1), C_MRD, 16'h0);
        for (int i = 0; i < 8; i++)
            apply(mk(3'(i), 3'(i), 3'd0, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0), C_RD1, 16'h0);

        repeat (3) @(posedge clk);
        chk("drain", 16'(exp_q.size()), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
